uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter; successor to the fixed 8N1/9600 TX.
- Accepts DATA_WIDTH-bit words through a valid/rdy handshake into an internal FIFO.
- Serialises each word as DATA_WIDTH/8 bytes, least-significant byte first, LSB-first bits.
- Baud divisor, parity and stop-bit count are programmable per word.
- Sits between packet logic and the board debug/console pin.

Parameters:
DATA_WIDTH, 8, input word width; multiple of 8, range 8..64
FIFO_DEPTH, 16, words buffered; power of two, minimum 2
DIV_WIDTH, 16, width of baud_div
DIV_RESET, 13020, suggested software default (125 MHz / 9600 - 1); informational only

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high, sampled on rising clk
valid  in  1  din is presented; written when valid && rdy
din  in  DATA_WIDTH  word to transmit
rdy  out  1  FIFO not full
baud_div  in  DIV_WIDTH  clocks per bit minus 1
parity_mode  in  2  0 none, 1 even, 2 odd, 3 mark (parity bit = 1)
two_stop  in  1  1 = two stop bits, 0 = one
tx  out  1  serial line, idle high
busy  out  1  frame in progress or FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  words held

Behaviour:
- Reset values: tx=1, rdy=1, busy=0, fifo_count=0. FIFO flushed, state IDLE, bit/byte counters 0. Reset mid-frame truncates the frame; tx is 1 from the next edge.
- Handshake: write only when valid && rdy. valid while !rdy is ignored; no overflow, no error flag. rdy is combinational !full. Simultaneous write and read when full is allowed.
- Bit period: exactly baud_div+1 clocks; baud_div=0 gives 1 clock per bit. The divisor counter runs only outside IDLE and reloads at each bit boundary.
- Config sampling: baud_div, parity_mode and two_stop are latched in LOAD once per word. Changes mid-word take effect on the next word.
- State machine: IDLE -> LOAD -> START -> DATA -> [PARITY] -> STOP -> (START for next byte | LOAD if FIFO non-empty | IDLE).
  - IDLE: tx=1. Issues a FIFO read when not empty.
  - LOAD: latches the FIFO word and config; byte index = 0.
  - START: tx=0 for one bit period.
  - DATA: 8 bits, LSB first.
  - PARITY: present only when parity_mode != 0. Parity covers the 8 bits of the current byte only.
  - STOP: tx=1 for one bit period, or two when two_stop is set.
- Latency: a word accepted on edge N into an empty, idle block drives tx low from edge N+3, exactly.
- Back-to-back bytes within a word: no gap; START follows STOP directly.
- Back-to-back words: at most one extra clock of idle-high between the final stop bit and the next start bit (LOAD cycle).
- busy: 1 from the edge after acceptance until the final stop bit ends with the FIFO empty.
- fifo_count: registered; updates one edge after a write or read.

Optional Feature:
UART_TX_BREAK_EN
- With the macro: adds input break_req (1 bit).
  - A break request seen in IDLE forces tx=0 for 16 bit periods (using the current baud_div), then returns to IDLE.
  - A request raised mid-frame is held off until the frame completes.
  - The FIFO keeps accepting words during a break.
- Without the macro: no port and no state; the block behaves exactly as above.

Decomposition:
- Package uart_pkg holds:
  - typedef uart_state_t (IDLE, LOAD, START, DATA, PARITY, STOP, BREAK);
  - typedef parity_t (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK);
  - localparams BREAK_BITS=16 and BITS_PER_BYTE=8.
- Reuse the existing team fifo module for buffering.
- One new sub-module, uart_baud_gen: loadable down-counter producing a 1-clock bit_tick, with enable and synchronous reload.

Test Plan:
- DATA_WIDTH=8, baud_div=3, parity none, one stop, din=0x55 -> tx low from edge N+3. Bit pattern 0,1,0,1,0,1,0,1,0,1 (start, bits, stop), each held 4 clocks. busy drops after 40 clocks.
- DATA_WIDTH=16, baud_div=1, even parity, din=0x01A5 -> byte 0xA5 then 0x01, each frame 11 bits. Parity bits are 0 then 1. No idle between the bytes.
- DATA_WIDTH=8, FIFO_DEPTH=4, baud_div=0: burst of 6 valid writes -> rdy drops after 4 writes are accepted and the FIFO drains. Exactly the accepted bytes appear on tx, in order; the rejected writes never appear.
- Odd parity with two_stop=1, din=0xFF -> parity bit 1 and tx high for 2 bit periods. Changing baud_div mid-frame does not alter the current frame.
- Reset asserted mid-DATA on a word with 3 more words queued -> tx=1, busy=0, fifo_count=0 and rdy=1 on the next edge. No further start bits appear.
- UART_TX_BREAK_EN: break_req pulse in IDLE with baud_div=2 -> tx low for 48 clocks. A word written during the break is sent afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_MARK
  } parity_t;

  localparam int BREAK_BITS    = 16;
  localparam int BITS_PER_BYTE = 8;

  // acc is the XOR of the data bits already sent for the current byte.
  function automatic logic parity_bit(input parity_t mode, input logic acc);
    case (mode)
      PAR_EVEN: return acc;
      PAR_ODD:  return ~acc;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data (valid the cycle after rd_en).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = rd_data_q;

  always_comb begin
    // A full FIFO may still take a write when a read frees a slot this cycle.
    push     = wr_en && (!full || rd_en);
    pop      = rd_en && !empty;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (pop) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: bit_tick pulses for one clock every load_val+1 enabled clocks.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic                 bit_tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    bit_tick = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (cnt_q == '0) begin
        bit_tick = 1'b1;
        cnt_d    = load_val;
      end else begin
        cnt_d = cnt_q - DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter fed by a word FIFO.
// Build option: define UART_TX_BREAK_EN to add the break_req input and BREAK state.
//
// state  | meaning
// IDLE   | line high, pop FIFO when a word is waiting
// LOAD   | latch word and line config, byte index 0
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | parity bit, only when parity is enabled
// STOP   | one or two stop bits (high)
// BREAK  | line held low for BREAK_BITS bit periods
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RESET  = 13020
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic                        rdy,
  input  logic [DIV_WIDTH-1:0]        baud_div,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                        break_req
`endif
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  uart_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  parity_t               par_mode_q, par_mode_d;
  logic                  two_stop_q, two_stop_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic                  par_acc_q, par_acc_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  fifo_rd, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  bit_tick, baud_load;
  logic                  brk_go, brk_hold;

  assign rdy  = !fifo_full;
  assign tx   = tx_q;
  assign busy = busy_q;

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (valid && rdy),
    .wr_data (din),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The divisor is sampled straight from the port while idle or loading,
  // so the first bit of a frame or break already uses the fresh value.
  assign baud_load = (state_q == IDLE) || (state_q == LOAD);

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (!baud_load),
    .load     (baud_load),
    .load_val (baud_load ? baud_div : div_q),
    .bit_tick (bit_tick)
  );

`ifdef UART_TX_BREAK_EN
  logic brk_pend_q, brk_pend_d;
  assign brk_go   = break_req || brk_pend_q;
  assign brk_hold = brk_go;
  assign brk_pend_d = (state_q == IDLE) ? 1'b0 : (brk_pend_q || break_req);
  always_ff @(posedge clk) begin
    if (rst) brk_pend_q <= 1'b0;
    else     brk_pend_q <= brk_pend_d;
  end
`else
  assign brk_go   = 1'b0;
  assign brk_hold = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    div_d      = div_q;
    par_mode_d = par_mode_q;
    two_stop_d = two_stop_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    par_acc_d  = par_acc_q;
    fifo_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = baud_div;
        if (brk_go) begin
          state_d   = BREAK;
          bit_cnt_d = '0;
        end else if (!fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        word_d     = fifo_rdata;
        div_d      = baud_div;
        par_mode_d = parity_t'(parity_mode);
        two_stop_d = two_stop;
        byte_idx_d = '0;
        bit_cnt_d  = '0;
        state_d    = START;
      end
      START: if (bit_tick) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        par_acc_d = 1'b0;
      end
      DATA: if (bit_tick) begin
        par_acc_d = par_acc_q ^ word_q[0];
        word_d    = word_q >> 1;
        if (bit_cnt_q == 4'(BITS_PER_BYTE - 1)) begin
          bit_cnt_d = '0;
          state_d   = (par_mode_q == PAR_NONE) ? STOP : PARITY;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      PARITY: if (bit_tick) begin
        state_d   = STOP;
        bit_cnt_d = '0;
      end
      STOP: if (bit_tick) begin
        if (two_stop_q && bit_cnt_q == '0) begin
          bit_cnt_d = 4'd1;
        end else begin
          bit_cnt_d = '0;
          if (byte_idx_q != BIDX_W'(BYTES - 1)) begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
            state_d    = START;
          end else if (!fifo_empty && !brk_hold) begin
            fifo_rd = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: if (bit_tick) begin
        if (bit_cnt_q == 4'(BREAK_BITS - 1)) state_d = IDLE;
        else                                  bit_cnt_d = bit_cnt_q + 4'd1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // tx and busy are registered from the current state, one clock behind it.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = word_q[0];
      PARITY:  tx_d = parity_bit(par_mode_q, par_acc_q);
      BREAK:   tx_d = 1'b0;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      div_q      <= DIV_WIDTH'(DIV_RESET);
      par_mode_q <= PAR_NONE;
      two_stop_q <= 1'b0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      par_acc_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      div_q      <= div_d;
      par_mode_q <= par_mode_d;
      two_stop_q <= two_stop_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      par_acc_q  <= par_acc_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench: an 8-bit/depth-4 and a 16-bit/depth-4 instance, each line decoded by a receiver model.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        break_req;

  logic        v8, rdy8, tx8, busy8;
  logic [7:0]  din8;
  logic [2:0]  cnt8;
  logic        v16, rdy16, tx16, busy16;
  logic [15:0] din16;
  logic [2:0]  cnt16;

  uart_tx_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) u_dut8 (
    .clk(clk), .rst(rst), .valid(v8), .din(din8), .rdy(rdy8),
    .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .tx(tx8), .busy(busy8), .fifo_count(cnt8)
`ifdef UART_TX_BREAK_EN
    , .break_req(break_req)
`endif
  );

  uart_tx_cfg #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) u_dut16 (
    .clk(clk), .rst(rst), .valid(v16), .din(din16), .rdy(rdy16),
    .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
    .tx(tx16), .busy(busy16), .fifo_count(cnt16)
`ifdef UART_TX_BREAK_EN
    , .break_req(1'b0)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb8[$];
  logic [7:0] sb16[$];
  bit mon_en8 = 1'b1;
  bit mon_en16 = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference frame: start, 8 data bits LSB first, optional parity, stop bit(s).
  function automatic logic [11:0] frame_bits(input logic [7:0] b, input logic [1:0] pm,
                                             input logic ts, output int nb);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
    nb = 9;
    if (pm != 2'd0) begin
      f[nb] = (pm == 2'd1) ? ^b : (pm == 2'd2) ? ~^b : 1'b1;
      nb++;
    end
    nb += ts ? 2 : 1;
    return f;
  endfunction

  task automatic rx_monitor(input bit wide);
    logic [11:0] fb;
    logic [7:0]  expb, rxb;
    logic        smp;
    int          nb, period, bad, qsz;
    bit          first;
    string       pfx;
    pfx = wide ? "rx16" : "rx8";
    forever begin
      @(negedge clk);
      if (!rst && (wide ? mon_en16 : mon_en8) && ((wide ? tx16 : tx8) == 1'b0)) begin
        period = int'(baud_div) + 1;
        qsz = wide ? sb16.size() : sb8.size();
        check({pfx, "_frame_expected"}, qsz > 0, 1);
        expb = 8'h00;
        if (qsz > 0) begin
          if (wide) expb = sb16.pop_front();
          else      expb = sb8.pop_front();
        end
        fb = frame_bits(expb, parity_mode, two_stop, nb);
        bad = 0;
        rxb = 8'h00;
        first = 1'b1;
        for (int b = 0; b < nb; b++) begin
          for (int c = 0; c < period; c++) begin
            if (!first) @(negedge clk);
            first = 1'b0;
            smp = wide ? tx16 : tx8;
            if (smp !== fb[b]) bad++;
            if (b >= 1 && b <= 8 && c == period / 2) rxb[b-1] = smp;
          end
        end
        check({pfx, "_byte"}, rxb, expb);
        check({pfx, "_bit_cycles_wrong"}, bad, 0);
      end
    end
  endtask

  initial rx_monitor(1'b0);
  initial rx_monitor(1'b1);

  task automatic write8(input logic [7:0] d, output bit acc, output logic [2:0] cnt_at);
    @(negedge clk);
    v8 = 1'b1;
    din8 = d;
    acc = rdy8;
    cnt_at = cnt8;
    if (acc) sb8.push_back(d);
    @(posedge clk);
    #1;
    v8 = 1'b0;
  endtask

  task automatic write16(input logic [15:0] d);
    @(negedge clk);
    v16 = 1'b1;
    din16 = d;
    if (rdy16) begin
      sb16.push_back(d[7:0]);
      sb16.push_back(d[15:8]);
    end
    @(posedge clk);
    #1;
    v16 = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((busy8 || busy16 || sb8.size() != 0 || sb16.size() != 0) && n < maxc) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_time", n < maxc, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    logic [2:0]  cat;
    int          n, acc_cnt, rej_cnt, lows, idx, nb;
    bit          full_ok;
    logic [43:0] got_w, exp_w;
    logic [11:0] fb;
    logic [7:0]  bytes16 [2];

    rst = 1'b1; v8 = 1'b0; v16 = 1'b0; din8 = '0; din16 = '0;
    baud_div = 16'd3; parity_mode = 2'd0; two_stop = 1'b0; break_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx8, 1);
    check("rst_rdy", rdy8, 1);
    check("rst_busy", busy8, 0);
    check("rst_count", cnt8, 0);
    check("rst_tx16", tx16, 1);
    @(negedge clk);
    rst = 1'b0;

    // 8N1, 4 clocks per bit, 0x55
    write8(8'h55, acc, cat);
    @(posedge clk); #1;
    check("t1_busy_n1", busy8, 1);
    check("t1_tx_n1", tx8, 1);
    @(posedge clk); #1;
    check("t1_tx_n2", tx8, 1);
    @(posedge clk); #1;
    check("t1_tx_n3", tx8, 0);
    n = 0;
    while (busy8 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t1_busy_clocks", n, 40);
    wait_drain(200);

    // 16-bit word, even parity, 2 clocks per bit, bytes back to back
    baud_div = 16'd1; parity_mode = 2'd1;
    write16(16'h01A5);
    n = 0;
    while (tx16 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t2_latency", n, 3);
    got_w[0] = tx16;
    for (int i = 1; i < 44; i++) begin
      @(posedge clk); #1;
      got_w[i] = tx16;
    end
    bytes16[0] = 8'hA5;
    bytes16[1] = 8'h01;
    idx = 0;
    exp_w = '0;
    for (int k = 0; k < 2; k++) begin
      fb = frame_bits(bytes16[k], 2'd1, 1'b0, nb);
      for (int b = 0; b < nb; b++) begin
        for (int r = 0; r < 2; r++) begin
          exp_w[idx] = fb[b];
          idx++;
        end
      end
    end
    check("t2_waveform", got_w, exp_w);
    wait_drain(300);

    // burst of 6 into a 4-deep FIFO at 1 clock per bit
    baud_div = 16'd0; parity_mode = 2'd0;
    acc_cnt = 0; rej_cnt = 0; full_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      write8(8'hC0 + 8'(i), acc, cat);
      if (acc) acc_cnt++;
      else begin
        rej_cnt++;
        if (cat != 3'd4) full_ok = 1'b0;
      end
    end
    check("t3_some_rejected", rej_cnt > 0, 1);
    check("t3_accepted_at_least_4", acc_cnt >= 4, 1);
    check("t3_full_when_rejected", full_ok, 1);
    wait_drain(400);
    check("t3_rdy_after_drain", rdy8, 1);
    check("t3_count_after_drain", cnt8, 0);

    // odd parity, two stop bits, divisor changed mid-frame
    baud_div = 16'd2; parity_mode = 2'd2; two_stop = 1'b1;
    write8(8'hFF, acc, cat);
    write8(8'h81, acc, cat);
    n = 0;
    while (tx8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4_start_seen", tx8, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    baud_div = 16'd7;
    wait_drain(600);

    // reset in the middle of DATA with 3 words still queued
    baud_div = 16'd3; parity_mode = 2'd0; two_stop = 1'b0;
    mon_en8 = 1'b0;
    for (int i = 0; i < 4; i++) write8(8'hA1 + 8'(i), acc, cat);
    repeat (8) @(posedge clk);
    #1;
    check("t5_busy_before", busy8, 1);
    check("t5_queued", cnt8, 3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_tx", tx8, 1);
    check("t5_rst_busy", busy8, 0);
    check("t5_rst_count", cnt8, 0);
    check("t5_rst_rdy", rdy8, 1);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx8 == 1'b0) lows++;
    end
    check("t5_no_start_after_rst", lows, 0);
    check("t5_busy_after", busy8, 0);
    sb8.delete();
    mon_en8 = 1'b1;

`ifdef UART_TX_BREAK_EN
    baud_div = 16'd2;
    mon_en8 = 1'b0;
    @(negedge clk);
    break_req = 1'b1;
    @(posedge clk); #1;
    break_req = 1'b0;
    fork
      begin
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (tx8 && n < 10);
        check("t6_break_started", tx8, 0);
        lows = 0;
        while (tx8 == 1'b0 && lows < 200) begin
          lows++;
          @(posedge clk); #1;
        end
        check("t6_break_clocks", lows, 48);
        mon_en8 = 1'b1;
      end
      begin
        repeat (5) @(posedge clk);
        write8(8'h3C, acc, cat);
        check("t6_accept_during_break", acc, 1);
      end
    join
    wait_drain(400);
`endif

    check("sb8_empty", sb8.size(), 0);
    check("sb16_empty", sb16.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
